mpf_svc_vtp_l2_arb: RTL

Round-robin arbiter that shares one VTP L2 translation service port among N per-port L1 miss handlers. Each client gets a one-entry request slot, a per-client outstanding-request limit and a busy flag. The busy flag is used for fence and ordered-request blocking. Client index is prepended to the L2 tag, and L2 responses are steered back to the originating client by that tag. The block sits between the L1 miss logic of every VTP translation port and the shared L2 TLB.

---
 rtl/mpf_svc_vtp_l2_arb.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mpf_svc_vtp_l2_arb.sv
// mpf_svc_vtp_l2_arb
// Shares one VTP L2 translation port among N_CLIENTS L1 miss handlers.
// Each client owns a one-entry request slot and an outstanding-request
// counter. A round-robin arbiter feeds a registered L2 request stage. L2
// responses are registered once and steered back by the client index held
// in the upper bits of the L2 tag.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cli_reqEn/VA/Tag    per-client request inputs (packed, client i at slice i)
//   cli_reqRdy          client slot can accept this cycle
//   cli_busy            client has requests accepted but not yet answered
//   cli_rspValid        one-hot response strobe
//   cli_rsp*            broadcast response payload
//   l2_req*             request to the shared L2 (tag = {client, client tag})
//   l2_rsp*             L2 response, cannot be back-pressured
module mpf_svc_vtp_l2_arb #(
    parameter int N_CLIENTS       = 4,
    parameter int VA_PAGE_BITS    = 36,
    parameter int PA_PAGE_BITS    = 40,
    parameter int CLI_TAG_BITS    = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CIDX           = $clog2(N_CLIENTS),
    localparam int L2_TAG_BITS    = CIDX + CLI_TAG_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_CLIENTS-1:0]              cli_reqEn,
    input  logic [N_CLIENTS*VA_PAGE_BITS-1:0] cli_reqVA,
    input  logic [N_CLIENTS*CLI_TAG_BITS-1:0] cli_reqTag,
    output logic [N_CLIENTS-1:0]              cli_reqRdy,
    output logic [N_CLIENTS-1:0]              cli_busy,
    output logic [N_CLIENTS-1:0]              cli_rspValid,
    output logic [PA_PAGE_BITS-1:0]           cli_rspPA,
    output logic                              cli_rspIsBigPage,
    output logic                              cli_rspError,
    output logic [CLI_TAG_BITS-1:0]           cli_rspTag,
    output logic                              l2_reqEn,
    output logic [VA_PAGE_BITS-1:0]           l2_reqVA,
    output logic [L2_TAG_BITS-1:0]            l2_reqTag,
    input  logic                              l2_reqRdy,
    input  logic                              l2_rspValid,
    input  logic [PA_PAGE_BITS-1:0]           l2_rspPA,
    input  logic                              l2_rspIsBigPage,
    input  logic                              l2_rspError,
    input  logic [L2_TAG_BITS-1:0]            l2_rspTag
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CIDX + 1;

    // Per-client request slots and outstanding counters
    logic [N_CLIENTS-1:0]    r_slotValid;
    logic [VA_PAGE_BITS-1:0] r_slotVA  [N_CLIENTS];
    logic [CLI_TAG_BITS-1:0] r_slotTag [N_CLIENTS];
    logic [CNT_W-1:0]        r_cnt     [N_CLIENTS];
    logic [CIDX-1:0]         r_rr;

    // L2 request stage
    logic                    r_l2ReqEn;
    logic [VA_PAGE_BITS-1:0] r_l2ReqVA;
    logic [L2_TAG_BITS-1:0]  r_l2ReqTag;

    // Registered L2 response
    logic                    r_rspValid;
    logic [PA_PAGE_BITS-1:0] r_rspPA;
    logic                    r_rspIsBigPage;
    logic                    r_rspError;
    logic [L2_TAG_BITS-1:0]  r_rspTag;

    logic [N_CLIENTS-1:0]    w_accept;
    logic [N_CLIENTS-1:0]    w_strobe;
    logic [CIDX-1:0]         w_rspIdx;
    logic                    w_advance;
    logic                    w_found;
    logic [CIDX-1:0]         w_winner;
    logic [CIDX-1:0]         w_rrNext;
    logic [SUM_W-1:0]        w_cand;

    // Slot readiness depends only on registered state so a client never
    // sees a combinational path from its own request back to its ready.
    always_comb begin
        cli_reqRdy = '0;
        cli_busy   = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cli_reqRdy[i] = !r_slotValid[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
            cli_busy[i]   = (r_cnt[i] != '0);
        end
        w_accept = cli_reqEn & cli_reqRdy;
    end

    // Response steering: an index outside the client range matches no
    // client, so the response is silently dropped.
    always_comb begin
        w_rspIdx = r_rspTag[L2_TAG_BITS-1 -: CIDX];
        w_strobe = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_strobe[i] = r_rspValid && (w_rspIdx == CIDX'(i));
        end
    end

    // Round-robin search starting at r_rr. The candidate index is formed
    // with one extra bit and folded back once, which handles client counts
    // that are not a power of two.
    always_comb begin
        w_advance = !r_l2ReqEn || l2_reqRdy;
        w_found   = 1'b0;
        w_winner  = '0;
        w_cand    = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            w_cand = SUM_W'(r_rr) + SUM_W'(k);
            if (w_cand >= SUM_W'(N_CLIENTS)) begin
                w_cand = w_cand - SUM_W'(N_CLIENTS);
            end
            if (!w_found && r_slotValid[w_cand[CIDX-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[CIDX-1:0];
            end
        end
        w_rrNext = (w_winner == CIDX'(N_CLIENTS - 1)) ? '0 : w_winner + 1'b1;
    end

    // Control state: slot valid bits, counters, pointer and the two valid
    // flags. Granting clears the winner's slot on the same edge the request
    // stage loads, so the client may refill it the cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slotValid <= '0;
            r_rr        <= '0;
            r_l2ReqEn   <= 1'b0;
            r_rspValid  <= 1'b0;
            for (int i = 0; i < N_CLIENTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_advance) begin
                r_l2ReqEn <= w_found;
                if (w_found) begin
                    r_slotValid[w_winner] <= 1'b0;
                    r_rr                  <= w_rrNext;
                end
            end
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (w_accept[i]) begin
                    r_slotValid[i] <= 1'b1;
                end
                // Accept and response together cancel; a response with
                // nothing counted (e.g. issued before a reset) saturates.
                case ({w_accept[i], w_strobe[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: ;
                endcase
            end
            r_rspValid <= l2_rspValid;
        end
    end

    // Payload registers carry no reset; their contents only matter while
    // the matching valid flag is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_accept[i]) begin
                r_slotVA[i]  <= cli_reqVA[i*VA_PAGE_BITS +: VA_PAGE_BITS];
                r_slotTag[i] <= cli_reqTag[i*CLI_TAG_BITS +: CLI_TAG_BITS];
            end
        end
        if (w_advance && w_found) begin
            r_l2ReqVA  <= r_slotVA[w_winner];
            r_l2ReqTag <= {w_winner, r_slotTag[w_winner]};
        end
        r_rspPA        <= l2_rspPA;
        r_rspIsBigPage <= l2_rspIsBigPage;
        r_rspError     <= l2_rspError;
        r_rspTag       <= l2_rspTag;
    end

    assign l2_reqEn         = r_l2ReqEn;
    assign l2_reqVA         = r_l2ReqVA;
    assign l2_reqTag        = r_l2ReqTag;
    assign cli_rspValid     = w_strobe;
    assign cli_rspPA        = r_rspPA;
    assign cli_rspIsBigPage = r_rspIsBigPage;
    assign cli_rspError     = r_rspError;
    assign cli_rspTag       = r_rspTag[CLI_TAG_BITS-1:0];

    // A client must not present a request while its slot is not ready.
    a_reqWhileNotRdy : assert property (@(posedge clk) disable iff (reset)
        ((cli_reqEn & ~cli_reqRdy) == '0));

endmodule
